// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_pkg                                                                  |
// | Shared types, constants and sizing helpers for the pipelined adder.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package adder_pkg;

   localparam int CNT_W = 16;

   function automatic int chunk_w(input int n, input int stages);
      return n / stages;
   endfunction

   // Per-stage control; operand and result vectors sit beside it because their width follows N.
   typedef struct packed {
      logic v;
      logic carry;
   } stage_t;

endpackage
`default_nettype wire

// File: rtl/adder_chunk_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_chunk_stage                                                          |
// | One registered CW-bit slice of the carry-chained adder with hold/advance.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adder_chunk_stage
   import adder_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = 2,
   parameter int LO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         v_i,
   input  logic         c_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] r_i,
   output stage_t       ctl_o,
   output logic [N-1:0] a_o,
   output logic [N-1:0] b_o,
   output logic [N-1:0] r_o
);

   stage_t         ctl_q, ctl_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   r_q, r_d;
   logic [CW:0]    chunk_sum;

   always_comb begin
      chunk_sum = {1'b0, a_i[LO +: CW]} + {1'b0, b_i[LO +: CW]} + {{CW{1'b0}}, c_i};
      ctl_d     = ctl_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      if (en_i) begin
         ctl_d.v = v_i;
         if (v_i) begin
            ctl_d.carry = chunk_sum[CW];
            a_d         = a_i;
            b_d         = b_i;
            // Result chunks at and above this slice are still zero on entry, so OR merges cleanly.
            r_d         = r_i | (N'(chunk_sum[CW-1:0]) << LO);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         r_q   <= '0;
      end else begin
         ctl_q <= ctl_d;
         a_q   <= a_d;
         b_q   <= b_d;
         r_q   <= r_d;
      end
   end

   assign ctl_o = ctl_q;
   assign a_o   = a_q;
   assign b_o   = b_q;
   assign r_o   = r_q;

endmodule
`default_nettype wire

// File: rtl/adder_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_pipe_responder                                                       |
// | Pipelined N-bit adder responder with per-stage valid and backpressure.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adder_pipe_responder
   import adder_pkg::*;
#(
   parameter int N      = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             valid,
   output logic             ready,
   output logic [N-1:0]     sum,
   output logic             carry,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [CNT_W-1:0] txn_count
);

   localparam int CW = chunk_w(N, STAGES);

   generate
      if ((N % STAGES) != 0) begin : g_bad_split
         $error("adder_pipe_responder: N must be a multiple of STAGES");
      end
   endgenerate

   logic [N-1:0]       a_s [0:STAGES];
   logic [N-1:0]       b_s [0:STAGES];
   logic [N-1:0]       r_s [0:STAGES];
   logic               v_s [0:STAGES];
   logic               c_s [0:STAGES];
   stage_t             ctl_s [0:STAGES-1];
   logic [STAGES-1:0]  adv;
   logic               adv_run;
   logic [CNT_W-1:0]   txn_count_q, txn_count_d;

   // A stage may advance when empty or when everything downstream moves this cycle.
   always_comb begin
      adv     = '0;
      adv_run = sum_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         adv_run = !ctl_s[s].v || adv_run;
         adv[s]  = adv_run;
      end
   end

   assign ready  = adv[0];
   assign v_s[0] = valid && ready;
   assign c_s[0] = 1'b0;
   assign a_s[0] = a;
   assign b_s[0] = b;
   assign r_s[0] = '0;

   generate
      for (genvar s = 0; s < STAGES; s++) begin : g_stage
         adder_chunk_stage #(
            .N  (N),
            .CW (CW),
            .LO (s * CW)
         ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en_i  (adv[s]),
            .v_i   (v_s[s]),
            .c_i   (c_s[s]),
            .a_i   (a_s[s]),
            .b_i   (b_s[s]),
            .r_i   (r_s[s]),
            .ctl_o (ctl_s[s]),
            .a_o   (a_s[s+1]),
            .b_o   (b_s[s+1]),
            .r_o   (r_s[s+1])
         );
         assign v_s[s+1] = ctl_s[s].v;
         assign c_s[s+1] = ctl_s[s].carry;
      end
   endgenerate

   assign sum       = r_s[STAGES];
   assign carry     = c_s[STAGES];
   assign sum_valid = v_s[STAGES];

   always_comb begin
      txn_count_d = txn_count_q;
      if (sum_valid && sum_ready) begin
         txn_count_d = txn_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_count_q <= '0;
      end else begin
         txn_count_q <= txn_count_d;
      end
   end

   assign txn_count = txn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adder_pipe_responder                                                    |
// | Directed and random scoreboard bench for the pipelined adder responder.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_adder_pipe_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  a, b;
   logic        valid;
   logic        ready;
   logic [3:0]  sum;
   logic        carry;
   logic        sum_valid;
   logic        sum_ready;
   logic [15:0] txn_count;

   int          checks = 0;
   int          errors = 0;
   logic [4:0]  sb [$];

   adder_pipe_responder #(.N(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .valid     (valid),
      .ready     (ready),
      .sum       (sum),
      .carry     (carry),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are stable between posedge+1 and the next posedge; sample them mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (sum_valid && sum_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("sb_result", {carry, sum}, sb.pop_front());
         end
         if (valid && ready) sb.push_back(5'(a) + 5'(b));
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [3:0] bp_a [4];
   logic [3:0] bp_b [4];
   logic [4:0] bp_exp0;
   int         idx;
   logic       acc;

   initial begin
      rst = 1'b1; valid = 1'b0; a = '0; b = '0; sum_ready = 1'b1;
      @(negedge clk);
      chk("rst_sum_valid", sum_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carry", carry, 0);
      chk("rst_txn", txn_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rel", ready, 1);
      next();

      // Single op: two cycles of latency, one cycle of sum_valid.
      valid = 1'b1; a = 4'h3; b = 4'h4;
      next();
      valid = 1'b0;
      @(negedge clk); chk("single_lat1_sv", sum_valid, 0);
      next();
      @(negedge clk); chk("single_sv", sum_valid, 1); chk("single_sum", sum, 4'h7); chk("single_carry", carry, 0);
      next();
      @(negedge clk); chk("single_sv_drop", sum_valid, 0); chk("single_txn", txn_count, 1);
      next();

      // Carries rippling across the chunk boundary.
      valid = 1'b1; a = 4'hF; b = 4'h1;
      next();
      a = 4'h6; b = 4'hA;
      next();
      valid = 1'b0;
      @(negedge clk); chk("carry1_sum", sum, 0); chk("carry1_c", carry, 1);
      next();
      @(negedge clk); chk("carry2_sum", sum, 0); chk("carry2_c", carry, 1);
      next();
      @(negedge clk); chk("carry_txn", txn_count, 3);
      next();

      // Back-to-back streaming.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         valid = (i < 16);
         a = 4'(i);
         b = 4'(15 - i * 3);
         @(negedge clk);
         if (i < 16) chk("stream_ready", ready, 1);
         if (i >= 2) chk("stream_sv", sum_valid, 1);
         next();
      end
      valid = 1'b0;
      next();
      @(negedge clk); chk("stream_txn", txn_count, 16);
      next();

      // Backpressure: output stalled for 5 cycles with the producer pushing.
      bp_a[0] = 4'h9; bp_b[0] = 4'h4;
      bp_a[1] = 4'hC; bp_b[1] = 4'h7;
      bp_a[2] = 4'h2; bp_b[2] = 4'hE;
      bp_a[3] = 4'h5; bp_b[3] = 4'h5;
      bp_exp0 = 5'h0D;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         sum_ready = (c >= 5);
         if (idx < 4) begin
            valid = 1'b1; a = bp_a[idx]; b = bp_b[idx];
         end else begin
            valid = 1'b0;
         end
         @(negedge clk);
         if (c < 2) chk("bp_ready_hi", ready, 1);
         if (c >= 2 && c <= 4) begin
            chk("bp_ready_lo", ready, 0);
            chk("bp_sv_hold", sum_valid, 1);
            chk("bp_data_hold", {carry, sum}, bp_exp0);
         end
         if (valid && ready) idx++;
         next();
      end
      chk("bp_all_taken", idx, 4);
      @(negedge clk); chk("bp_txn", txn_count, 20);
      next();

      // Asynchronous reset with two operations in flight.
      sum_ready = 1'b0;
      valid = 1'b1; a = 4'h5; b = 4'h6;
      next();
      a = 4'h7; b = 4'h8;
      next();
      valid = 1'b0;
      chk("mid_inflight_sv", sum_valid, 1);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_sv", sum_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_carry", carry, 0);
      chk("mid_rst_txn", txn_count, 0);
      next();
      rst = 1'b0;
      sum_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("mid_rel_ready", ready, 1);
         chk("mid_no_stale", sum_valid, 0);
         next();
      end

      // Random operands with random output stalls; producer holds while not accepted.
      acc = 1'b1;
      for (int n = 0; n < 300; n++) begin
         sum_ready = ($urandom_range(0, 3) != 0);
         if (!valid || acc) begin
            valid = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            b = 4'($urandom);
         end
         @(negedge clk);
         acc = valid && ready;
         next();
      end
      valid = 1'b0;
      sum_ready = 1'b1;
      for (int n = 0; n < 10 && sb.size() != 0; n++) next();
      chk("rand_drained", sb.size(), 0);

      // Counter wrap after 65535 retired results.
      do_reset();
      sum_ready = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         valid = 1'b1;
         a = 4'(i);
         b = 4'(i >> 4);
         next();
      end
      valid = 1'b0;
      repeat (3) next();
      @(negedge clk); chk("wrap_pre", txn_count, 16'hFFFF);
      next();
      valid = 1'b1; a = 4'hA; b = 4'h3;
      next();
      valid = 1'b0;
      repeat (2) next();
      @(negedge clk); chk("wrap_zero", txn_count, 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
